// File: rtl/sensor_pkg.sv
// Shared defaults and fault-monitor state encoding for the sensor front end.
package sensor_pkg;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 50000;
    localparam int unsigned DEFAULT_FAULT_CYCLES    = 500000;
    localparam int unsigned DEFAULT_CNT_W           = 20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        FAULT = 2'd2
    } faultState_t;

endpackage

// File: rtl/debounce_channel.sv
// One raw sensor line: 2-flop synchronizer, counting debouncer and
// registered rise/fall pulses aligned with the new debounced level.
module debounce_channel
    import sensor_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = DEFAULT_CNT_W
) (
    input  logic clock,
    input  logic reset_n,
    input  logic rawIn,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             syncMeta;
    logic             syncOut;
    logic [CNT_W-1:0] stableCnt;
    logic             differ;
    logic             accept;

    // Bring the asynchronous pin into the clock domain.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            syncMeta <= 1'b0;
            syncOut  <= 1'b0;
        end else begin
            syncMeta <= rawIn;
            syncOut  <= syncMeta;
        end
    end

    assign differ = syncOut ^ level;
    assign accept = differ && (stableCnt == LAST_COUNT);

    // Accept a new level after DEBOUNCE_CYCLES consecutive differing samples;
    // pulses are registered alongside the level so both appear together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            level     <= 1'b0;
            stableCnt <= '0;
            rise      <= 1'b0;
            fall      <= 1'b0;
        end else begin
            rise <= accept & ~level;
            fall <= accept & level;
            if (accept) begin
                level     <= ~level;
                stableCnt <= '0;
            end else if (differ) begin
                stableCnt <= stableCnt + 1'b1;
            end else begin
                stableCnt <= '0;
            end
        end
    end

endmodule

// File: rtl/sensor_conditioner.sv
// Conditions the cup-present / cup-full Arduino lines for the pump FSM and
// raises a sticky fault when "full" is seen without a cup for too long.
module sensor_conditioner
    import sensor_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned FAULT_CYCLES    = DEFAULT_FAULT_CYCLES,
    parameter int unsigned CNT_W           = DEFAULT_CNT_W
) (
    input  logic clock,
    input  logic reset_n,
    input  logic OutArd01,
    input  logic OutArd02,
    input  logic fault_clear,
    output logic Sensor01,
    output logic Sensor02,
    output logic cup_arrived,
    output logic cup_removed,
    output logic cup_filled,
    output logic sensor_fault
);

    localparam logic [CNT_W-1:0] LAST_FAULT = CNT_W'(FAULT_CYCLES - 1);

    logic             deb1;
    logic             deb2;
    logic             unusedCupEmptied;
    logic             implausible;
    faultState_t      faultState;
    logic [CNT_W-1:0] faultCnt;

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) cupPresentChan (
        .clock   (clock),
        .reset_n (reset_n),
        .rawIn   (OutArd01),
        .level   (deb1),
        .rise    (cup_arrived),
        .fall    (cup_removed)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) cupFullChan (
        .clock   (clock),
        .reset_n (reset_n),
        .rawIn   (OutArd02),
        .level   (deb2),
        .rise    (cup_filled),
        .fall    (unusedCupEmptied)
    );

    assign implausible = deb2 & ~deb1;

    // Fault monitor: count consecutive implausible cycles, latch the fault,
    // release only on an explicit clear once the condition has gone.
    // IDLE and COUNT share one branch: in IDLE the counter is 0, so the
    // terminal compare also covers FAULT_CYCLES == 1.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            faultState   <= IDLE;
            faultCnt     <= '0;
            sensor_fault <= 1'b0;
        end else begin
            unique case (faultState)
                IDLE, COUNT: begin
                    if (implausible) begin
                        if (faultCnt == LAST_FAULT) begin
                            faultState   <= FAULT;
                            sensor_fault <= 1'b1;
                        end else begin
                            faultState <= COUNT;
                            faultCnt   <= faultCnt + 1'b1;
                        end
                    end else begin
                        faultState <= IDLE;
                        faultCnt   <= '0;
                    end
                end
                FAULT: begin
                    if (fault_clear && !implausible) begin
                        faultState   <= IDLE;
                        faultCnt     <= '0;
                        sensor_fault <= 1'b0;
                    end
                end
                default: begin
                    faultState   <= IDLE;
                    faultCnt     <= '0;
                    sensor_fault <= 1'b0;
                end
            endcase
        end
    end

    assign Sensor02 = deb2;
    assign Sensor01 = deb1 & ~sensor_fault;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Bench for sensor_conditioner: directed scenarios plus random stimulus,
// checked every cycle against a history-based reference model.
module tb_sensor_conditioner;

    localparam int unsigned DEB = 4;
    localparam int unsigned FLT = 10;
    localparam int unsigned CW  = 8;

    logic clock;
    logic reset_n;
    logic OutArd01;
    logic OutArd02;
    logic fault_clear;
    logic Sensor01;
    logic Sensor02;
    logic cup_arrived;
    logic cup_removed;
    logic cup_filled;
    logic sensor_fault;

    sensor_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .FAULT_CYCLES    (FLT),
        .CNT_W           (CW)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .OutArd01     (OutArd01),
        .OutArd02     (OutArd02),
        .fault_clear  (fault_clear),
        .Sensor01     (Sensor01),
        .Sensor02     (Sensor02),
        .cup_arrived  (cup_arrived),
        .cup_removed  (cup_removed),
        .cup_filled   (cup_filled),
        .sensor_fault (sensor_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cycleNo = 0;

    // Reference model: raw input history since reset, accepted levels,
    // pulses of the last edge, fault flag and implausible run length.
    logic        hist1[$];
    logic        hist2[$];
    logic        mLvl1, mLvl2;
    logic        mRise1, mFall1, mRise2;
    logic        mFault;
    int unsigned condRun;

    int unsigned seenArrived, seenRemoved, seenFilled;

    function automatic logic rawAt(input int ch, input int idx);
        if (idx < 0) return 1'b0;
        return (ch == 1) ? hist1[idx] : hist2[idx];
    endfunction

    // The level flips once the DEB most recent synchronized samples (raw
    // values from 2..DEB+1 edges ago) all disagree with it.
    function automatic logic flips(input int ch, input int n, input logic lvl);
        for (int i = 2; i <= int'(DEB) + 1; i++)
            if (rawAt(ch, n - i) == lvl) return 1'b0;
        return 1'b1;
    endfunction

    task automatic modelReset();
        hist1.delete();
        hist2.delete();
        mLvl1 = 1'b0; mLvl2 = 1'b0;
        mRise1 = 1'b0; mFall1 = 1'b0; mRise2 = 1'b0;
        mFault = 1'b0;
        condRun = 0;
    endtask

    task automatic modelEdge(input logic a, input logic b, input logic clr, input logic preCond);
        int n;
        logic f1, f2;
        if (!mFault) begin
            if (preCond) begin
                condRun++;
                if (condRun >= FLT) mFault = 1'b1;
            end else begin
                condRun = 0;
            end
        end else if (clr && !preCond) begin
            mFault = 1'b0;
            condRun = 0;
        end
        hist1.push_back(a);
        hist2.push_back(b);
        n = hist1.size() - 1;
        f1 = flips(1, n, mLvl1);
        f2 = flips(2, n, mLvl2);
        mRise1 = f1 & ~mLvl1;
        mFall1 = f1 & mLvl1;
        mRise2 = f2 & ~mLvl2;
        if (f1) mLvl1 = ~mLvl1;
        if (f2) mLvl2 = ~mLvl2;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, cycleNo, obs, exp);
        end
    endtask

    task automatic checkOutputs();
        check("Sensor01", Sensor01, mLvl1 & ~mFault);
        check("Sensor02", Sensor02, mLvl2);
        check("cup_arrived", cup_arrived, mRise1);
        check("cup_removed", cup_removed, mFall1);
        check("cup_filled", cup_filled, mRise2);
        check("sensor_fault", sensor_fault, mFault);
    endtask

    task automatic tick(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            logic a, b, clr, preCond;
            a = OutArd01;
            b = OutArd02;
            clr = fault_clear;
            preCond = mLvl2 & ~mLvl1;
            @(posedge clock);
            #1;
            cycleNo++;
            if (reset_n) modelEdge(a, b, clr, preCond);
            seenArrived += cup_arrived;
            seenRemoved += cup_removed;
            seenFilled  += cup_filled;
            checkOutputs();
        end
    endtask

    task automatic doReset(input int unsigned holdCycles);
        reset_n = 1'b0;
        #1;
        modelReset();
        checkOutputs();
        tick(holdCycles);
        reset_n = 1'b1;
    endtask

    initial begin
        int unsigned holdA, holdB;

        // Reset with both lines high: nothing moves until release.
        reset_n = 1'b0;
        OutArd01 = 1'b1;
        OutArd02 = 1'b1;
        fault_clear = 1'b0;
        seenArrived = 0; seenRemoved = 0; seenFilled = 0;
        modelReset();
        #1;
        checkOutputs();
        tick(3);
        reset_n = 1'b1;
        tick(5);
        check("rst_s01_still_low", Sensor01, 1'b0);
        tick(1);
        check("rst_s01_rise", Sensor01, 1'b1);
        check("rst_s02_rise", Sensor02, 1'b1);
        check("rst_arrived_pulse", cup_arrived, 1'b1);
        check("rst_filled_pulse", cup_filled, 1'b1);
        tick(1);
        check("rst_arrived_single", cup_arrived, 1'b0);
        check("rst_filled_single", cup_filled, 1'b0);
        OutArd01 = 1'b0;
        OutArd02 = 1'b0;
        tick(8);

        // 3-cycle glitch is rejected; 4-cycle pulse is accepted at k+5.
        seenArrived = 0;
        OutArd01 = 1'b1;
        tick(3);
        OutArd01 = 1'b0;
        tick(8);
        check("glitch_s01", Sensor01, 1'b0);
        check("glitch_no_arrive", logic'(seenArrived == 0), 1'b1);
        OutArd01 = 1'b1;
        tick(4);
        OutArd01 = 1'b0;
        tick(2);
        check("pulse4_s01", Sensor01, 1'b1);
        tick(8);

        // Normal fill: arrive, fill, remove both.
        seenArrived = 0; seenRemoved = 0; seenFilled = 0;
        OutArd01 = 1'b1;
        tick(8);
        OutArd02 = 1'b1;
        tick(8);
        OutArd01 = 1'b0;
        OutArd02 = 1'b0;
        tick(8);
        check("fill_one_arrive", logic'(seenArrived == 1), 1'b1);
        check("fill_one_filled", logic'(seenFilled == 1), 1'b1);
        check("fill_one_removed", logic'(seenRemoved == 1), 1'b1);
        check("fill_no_fault", sensor_fault, 1'b0);

        // Full-without-cup for 9 cycles: below threshold.
        OutArd02 = 1'b1;
        tick(9);
        OutArd02 = 1'b0;
        tick(10);
        check("nine_no_fault", sensor_fault, 1'b0);

        // Held long enough: fault latches and masks Sensor01.
        OutArd02 = 1'b1;
        tick(20);
        check("fault_set", sensor_fault, 1'b1);
        fault_clear = 1'b1;
        tick(1);
        fault_clear = 1'b0;
        check("clear_ignored", sensor_fault, 1'b1);
        OutArd01 = 1'b1;
        tick(8);
        check("s01_masked", Sensor01, 1'b0);
        check("fault_held", sensor_fault, 1'b1);
        fault_clear = 1'b1;
        tick(1);
        fault_clear = 1'b0;
        check("fault_cleared", sensor_fault, 1'b0);
        check("s01_unmasked", Sensor01, 1'b1);
        OutArd01 = 1'b0;
        OutArd02 = 1'b0;
        tick(8);

        // Reset two cycles into a debounce count discards progress.
        seenArrived = 0;
        OutArd01 = 1'b1;
        tick(4);
        doReset(2);
        tick(5);
        check("rstmid_no_early", Sensor01, 1'b0);
        check("rstmid_no_pulse", logic'(seenArrived == 0), 1'b1);
        tick(1);
        check("rstmid_restart", Sensor01, 1'b1);
        OutArd01 = 1'b0;
        tick(8);

        // Random stimulus with varied hold lengths, one reset midway.
        holdA = 0;
        holdB = 0;
        for (int unsigned c = 0; c < 600; c++) begin
            if (holdA == 0) begin
                OutArd01 = 1'($urandom_range(0, 1));
                holdA = $urandom_range(1, 9);
            end
            if (holdB == 0) begin
                OutArd02 = 1'($urandom_range(0, 1));
                holdB = $urandom_range(1, 24);
            end
            fault_clear = ($urandom_range(0, 5) == 0);
            holdA--;
            holdB--;
            if (c == 300) doReset(1);
            tick(1);
        end
        fault_clear = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
